sc_statemachine_game: RTL and testbench
=======================================

SC_STATEMACHINE_GAME -- requirements
Module: SC_STATEMACHINE_GAME

Interface
REQ-001 SHALL provide parameter LIVES_INIT, default 3, meaning lives loaded at reset and restart (range 1..3).
REQ-002 SHALL provide parameter SCORE_WIN, default 21, meaning hit count that ends the game as a win (range 1..255).
REQ-003 SHALL provide parameter FLY_MAX, default 7, meaning shift ticks before an unhit bullet leaves the top row.
REQ-004 SHALL have one clock and a synchronous active-low reset: SC_STATEMACHINE_GAME_CLOCK_50 (input, 1, system clock) and SC_STATEMACHINE_GAME_RESET_InLow (input, 1, synchronous reset, active low).
REQ-005 SHALL have SC_STATEMACHINE_GAME_fire_InLow (input, 1): raw fire button, active low, asynchronous to the clock.
REQ-006 SHALL have SC_STATEMACHINE_GAME_tick_InHigh (input, 1): one-cycle game-step strobe.
REQ-007 SHALL have SC_STATEMACHINE_GAME_lose_InHigh (input, 1): comparator lose flag, alien overlaps ship row.
REQ-008 SHALL have SC_STATEMACHINE_GAME_statebullet_InHigh (input, 1): comparator bullet flag; 0 means bullet overlaps an alien.
REQ-009 SHALL have SC_STATEMACHINE_GAME_bulletload_OutHigh, _bulletshift_OutHigh and _bulletclear_OutHigh (outputs, 1 each): one-cycle commands to the bullet shifter.
REQ-010 SHALL have SC_STATEMACHINE_GAME_state_Out (output, 3, current state code), _score_Out (output, 8, hit count), _lives_Out (output, 2, remaining lives), _gameover_OutHigh (output, 1) and _win_OutHigh (output, 1).

Function
REQ-011 SHALL pass fire through a 2-flop synchronizer and produce a one-cycle press pulse on the synchronized 1->0 edge; holding the button SHALL yield exactly one pulse.
REQ-012 SHALL encode the states as START=0, READY=1, LOAD=2, FLY=3, HIT=4, DEAD=5, OVER=6, WIN=7.
REQ-013 START: go to READY on press.
REQ-014 READY: go to LOAD on press.
REQ-015 LOAD: lasts exactly one cycle, asserts bulletload, clears the fly counter, then goes to FLY.
REQ-016 FLY: on each tick, assert bulletshift and increment the 3-bit fly counter; go to HIT when statebullet=0 (sampled every cycle, not only on tick).
REQ-017 FLY: when the counter reaches FLY_MAX and no hit occurred, assert bulletclear and go to READY.
REQ-018 HIT: lasts one cycle, asserts bulletclear and increments score, saturating at 255; go to WIN when the new score equals SCORE_WIN, else READY.
REQ-019 SHALL go to DEAD when lose=1 in READY, LOAD or FLY; lose SHALL take priority over a hit and over fly expiry in the same cycle.
REQ-020 DEAD: lasts one cycle, asserts bulletclear and decrements lives; go to OVER when lives was 1, else READY.
REQ-021 OVER and WIN: hold gameover=1 or win=1 respectively; on press, reload score=0 and lives=LIVES_INIT and go to START.
REQ-022 SHALL ignore tick, lose and statebullet in START, OVER and WIN.
REQ-023 SHALL register all outputs from state and counters, with no combinational path from any input to any output; command pulses SHALL appear in the cycle the FSM occupies the issuing state.
REQ-024 SHALL never assert bulletload, bulletshift and bulletclear in the same cycle.

Reset
REQ-025 SHALL, while reset is low at a clock edge, set state=START, score=0, lives=LIVES_INIT, fly counter=0, all pulse outputs=0, gameover=0, win=0, and the synchronizer flops to 1 (released).
REQ-026 SHALL abort any in-progress operation on reset, including mid-FLY, without issuing a bulletclear pulse.

Configuration
REQ-027 With SC_STATEMACHINE_GAME_AUTOFIRE_EN defined, READY SHALL also go to LOAD on tick with no press required.
REQ-028 Without SC_STATEMACHINE_GAME_AUTOFIRE_EN, READY SHALL go to LOAD only on press, and the tick input SHALL have no effect in READY.

Verification
REQ-029 Reset low for 2 cycles then high -> state=0, score=0, lives=3, all pulses 0.
REQ-030 Press, press, then statebullet=0 on the 3rd FLY tick -> bulletload once, bulletshift 3 times, bulletclear once, score=1, state=READY.
REQ-031 Launch with statebullet held at 1 for 7 ticks -> bulletshift 7 times, then bulletclear, state=READY, score unchanged.
REQ-032 lose=1 and statebullet=0 in the same FLY cycle -> DEAD, lives 3->2, score unchanged.
REQ-033 Three lose events -> lives=0, state=6, gameover=1; next press -> state=0, lives=3, score=0.
REQ-034 Parameter SCORE_WIN=2 with two hits -> state=7, win=1; fire held low for 100 cycles produces exactly one press.

Source files
------------

// File: rtl/sc_statemachine_game.sv
// Shooter-game control FSM: fire synchronizer, bullet shifter commands, score/lives bookkeeping.
// Define SC_STATEMACHINE_GAME_AUTOFIRE_EN to also launch from READY on every tick.
module sc_statemachine_game #(
    parameter int LIVES_INIT = 3,
    parameter int SCORE_WIN  = 21,
    parameter int FLY_MAX    = 7
) (
    input  logic       SC_STATEMACHINE_GAME_CLOCK_50,
    input  logic       SC_STATEMACHINE_GAME_RESET_InLow,
    input  logic       SC_STATEMACHINE_GAME_fire_InLow,
    input  logic       SC_STATEMACHINE_GAME_tick_InHigh,
    input  logic       SC_STATEMACHINE_GAME_lose_InHigh,
    input  logic       SC_STATEMACHINE_GAME_statebullet_InHigh,
    output logic       SC_STATEMACHINE_GAME_bulletload_OutHigh,
    output logic       SC_STATEMACHINE_GAME_bulletshift_OutHigh,
    output logic       SC_STATEMACHINE_GAME_bulletclear_OutHigh,
    output logic [2:0] SC_STATEMACHINE_GAME_state_Out,
    output logic [7:0] SC_STATEMACHINE_GAME_score_Out,
    output logic [1:0] SC_STATEMACHINE_GAME_lives_Out,
    output logic       SC_STATEMACHINE_GAME_gameover_OutHigh,
    output logic       SC_STATEMACHINE_GAME_win_OutHigh
);

    typedef enum logic [2:0] {
        START = 3'd0,
        READY = 3'd1,
        LOAD  = 3'd2,
        FLY   = 3'd3,
        HIT   = 3'd4,
        DEAD  = 3'd5,
        OVER  = 3'd6,
        WIN   = 3'd7
    } state_t;

    localparam logic [2:0] FLY_LIMIT    = 3'(FLY_MAX);
    localparam logic [7:0] SCORE_TARGET = 8'(SCORE_WIN);
    localparam logic [1:0] LIVES_RELOAD = 2'(LIVES_INIT);

    wire clk   = SC_STATEMACHINE_GAME_CLOCK_50;
    wire rst_n = SC_STATEMACHINE_GAME_RESET_InLow;
    wire tick  = SC_STATEMACHINE_GAME_tick_InHigh;
    wire lose  = SC_STATEMACHINE_GAME_lose_InHigh;
    wire hit   = ~SC_STATEMACHINE_GAME_statebullet_InHigh;

    state_t     state, state_next;
    logic [2:0] fly_cnt, fly_cnt_next;
    logic [7:0] score, score_next;
    logic [1:0] lives, lives_next;
    logic       load_next, shift_next, clear_next;
    logic       load_q, shift_q, clear_q, gameover_q, win_q;
    logic       sync1, sync2, sync_prev, press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= SC_STATEMACHINE_GAME_fire_InLow;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign press = sync_prev & ~sync2;

    // Command pulses are computed from the next state and registered, so each one
    // lands in the cycle the FSM sits in the state that issues it. Fly expiry
    // spends one extra FLY cycle so its clear never overlaps the last shift.
    always_comb begin
        state_next   = state;
        fly_cnt_next = fly_cnt;
        score_next   = score;
        lives_next   = lives;
        load_next    = 1'b0;
        shift_next   = 1'b0;
        clear_next   = 1'b0;
        case (state)
            START: if (press) state_next = READY;
            READY: begin
                if (lose)
                    state_next = DEAD;
                else if (press)
                    state_next = LOAD;
`ifdef SC_STATEMACHINE_GAME_AUTOFIRE_EN
                else if (tick)
                    state_next = LOAD;
`endif
            end
            LOAD: begin
                fly_cnt_next = 3'd0;
                state_next   = lose ? DEAD : FLY;
            end
            FLY: begin
                if (lose)
                    state_next = DEAD;
                else if (clear_q)
                    state_next = READY;
                else if (hit)
                    state_next = HIT;
                else if (fly_cnt == FLY_LIMIT)
                    clear_next = 1'b1;
                else if (tick) begin
                    shift_next   = 1'b1;
                    fly_cnt_next = fly_cnt + 3'd1;
                end
            end
            HIT: begin
                score_next = (score == 8'hFF) ? score : score + 8'd1;
                state_next = (score_next == SCORE_TARGET) ? WIN : READY;
            end
            DEAD: begin
                lives_next = lives - 2'd1;
                state_next = (lives == 2'd1) ? OVER : READY;
            end
            OVER, WIN: begin
                if (press) begin
                    state_next = START;
                    score_next = 8'd0;
                    lives_next = LIVES_RELOAD;
                end
            end
            default: state_next = START;
        endcase
        load_next  = (state_next == LOAD);
        clear_next = clear_next | (state_next == HIT) | (state_next == DEAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= START;
            fly_cnt    <= 3'd0;
            score      <= 8'd0;
            lives      <= LIVES_RELOAD;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            clear_q    <= 1'b0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state      <= state_next;
            fly_cnt    <= fly_cnt_next;
            score      <= score_next;
            lives      <= lives_next;
            load_q     <= load_next;
            shift_q    <= shift_next;
            clear_q    <= clear_next;
            gameover_q <= (state_next == OVER);
            win_q      <= (state_next == WIN);
        end
    end

    assign SC_STATEMACHINE_GAME_bulletload_OutHigh  = load_q;
    assign SC_STATEMACHINE_GAME_bulletshift_OutHigh = shift_q;
    assign SC_STATEMACHINE_GAME_bulletclear_OutHigh = clear_q;
    assign SC_STATEMACHINE_GAME_state_Out           = state;
    assign SC_STATEMACHINE_GAME_score_Out           = score;
    assign SC_STATEMACHINE_GAME_lives_Out           = lives;
    assign SC_STATEMACHINE_GAME_gameover_OutHigh    = gameover_q;
    assign SC_STATEMACHINE_GAME_win_OutHigh         = win_q;

endmodule

// File: tb/tb_sc_statemachine_game.sv
// Directed bench for sc_statemachine_game (SCORE_WIN=2 so a win is reachable quickly).
module tb_sc_statemachine_game;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fire_n = 1'b1;
    logic       tick = 1'b0;
    logic       lose = 1'b0;
    logic       statebullet = 1'b1;
    logic       bulletload, bulletshift, bulletclear;
    logic [2:0] state;
    logic [7:0] score;
    logic [1:0] lives;
    logic       gameover, win;

    int total = 0;
    int bad = 0;
    int n_load = 0;
    int n_shift = 0;
    int n_clear = 0;
    int overlap_seen = 0;
    int snap_load, snap_shift, snap_clear;

    always #5 clk = ~clk;

    sc_statemachine_game #(.LIVES_INIT(3), .SCORE_WIN(2), .FLY_MAX(7)) dut (
        .SC_STATEMACHINE_GAME_CLOCK_50           (clk),
        .SC_STATEMACHINE_GAME_RESET_InLow        (rst_n),
        .SC_STATEMACHINE_GAME_fire_InLow         (fire_n),
        .SC_STATEMACHINE_GAME_tick_InHigh        (tick),
        .SC_STATEMACHINE_GAME_lose_InHigh        (lose),
        .SC_STATEMACHINE_GAME_statebullet_InHigh (statebullet),
        .SC_STATEMACHINE_GAME_bulletload_OutHigh (bulletload),
        .SC_STATEMACHINE_GAME_bulletshift_OutHigh(bulletshift),
        .SC_STATEMACHINE_GAME_bulletclear_OutHigh(bulletclear),
        .SC_STATEMACHINE_GAME_state_Out          (state),
        .SC_STATEMACHINE_GAME_score_Out          (score),
        .SC_STATEMACHINE_GAME_lives_Out          (lives),
        .SC_STATEMACHINE_GAME_gameover_OutHigh   (gameover),
        .SC_STATEMACHINE_GAME_win_OutHigh        (win)
    );

    // Pulse tallies and a sticky flag for any cycle with two commands at once.
    always @(negedge clk) begin
        n_load  += int'(bulletload);
        n_shift += int'(bulletshift);
        n_clear += int'(bulletclear);
        if ($countones({bulletload, bulletshift, bulletclear}) > 1)
            overlap_seen = 1;
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_fire();
        fire_n = 1'b0;
        step(4);
        fire_n = 1'b1;
        step(4);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    task automatic snapshot();
        snap_load  = n_load;
        snap_shift = n_shift;
        snap_clear = n_clear;
    endtask

    initial begin
        $display("[TB] start");
        step(2);
        rst_n = 1'b1;
        check_output("reset_state", state, 0);
        check_output("reset_score", score, 0);
        check_output("reset_lives", lives, 3);
        check_output("reset_pulses", {bulletload, bulletshift, bulletclear}, 0);
        check_output("reset_flags", {gameover, win}, 0);

        // Launch, three shifts, then a hit.
        snapshot();
        press_fire();
        check_output("start_to_ready", state, 1);
        do_tick();
        check_output("tick_ignored_in_ready", state, 1);
        press_fire();
        check_output("in_fly", state, 3);
        repeat (3) do_tick();
        statebullet = 1'b0;
        step(1);
        check_output("hit_state", state, 4);
        check_output("hit_clear", bulletclear, 1);
        statebullet = 1'b1;
        step(1);
        check_output("after_hit_state", state, 1);
        check_output("after_hit_score", score, 1);
        check_output("hit_loads", n_load - snap_load, 1);
        check_output("hit_shifts", n_shift - snap_shift, 3);
        check_output("hit_clears", n_clear - snap_clear, 1);

        // Bullet flies off the top after seven shifts.
        snapshot();
        press_fire();
        check_output("fly2_state", state, 3);
        repeat (7) do_tick();
        check_output("expire_state", state, 3);
        check_output("expire_clear", bulletclear, 1);
        step(1);
        check_output("expire_ready", state, 1);
        check_output("expire_shifts", n_shift - snap_shift, 7);
        check_output("expire_clears", n_clear - snap_clear, 1);
        check_output("expire_score", score, 1);

        // Lose beats hit in the same FLY cycle.
        press_fire();
        lose = 1'b1;
        statebullet = 1'b0;
        step(1);
        check_output("lose_priority_state", state, 5);
        lose = 1'b0;
        statebullet = 1'b1;
        step(1);
        check_output("dead_lives", lives, 2);
        check_output("dead_score", score, 1);
        check_output("dead_ready", state, 1);

        // Two more deaths from READY end the game.
        repeat (2) begin
            lose = 1'b1;
            step(1);
            lose = 1'b0;
            step(1);
        end
        check_output("over_state", state, 6);
        check_output("over_flag", gameover, 1);
        check_output("over_lives", lives, 0);
        lose = 1'b1;
        tick = 1'b1;
        statebullet = 1'b0;
        step(2);
        lose = 1'b0;
        tick = 1'b0;
        statebullet = 1'b1;
        check_output("over_ignores_inputs", state, 6);
        press_fire();
        check_output("restart_state", state, 0);
        check_output("restart_lives", lives, 3);
        check_output("restart_score", score, 0);
        check_output("restart_gameover", gameover, 0);

        // Two hits reach SCORE_WIN=2.
        press_fire();
        repeat (2) begin
            press_fire();
            statebullet = 1'b0;
            step(1);
            statebullet = 1'b1;
            step(1);
        end
        check_output("win_state", state, 7);
        check_output("win_flag", win, 1);
        check_output("win_score", score, 2);

        // Holding fire produces one press only: WIN -> START, never READY.
        fire_n = 1'b0;
        step(100);
        check_output("held_fire_state", state, 0);
        fire_n = 1'b1;
        step(4);
        check_output("released_fire_state", state, 0);
        check_output("win_cleared", win, 0);

        // Reset in the middle of a flight.
        press_fire();
        press_fire();
        do_tick();
        check_output("pre_reset_fly", state, 3);
        snapshot();
        rst_n = 1'b0;
        step(1);
        check_output("midfly_reset_state", state, 0);
        check_output("midfly_reset_clear", bulletclear, 0);
        rst_n = 1'b1;
        step(2);
        check_output("midfly_no_clear", n_clear - snap_clear, 0);
        check_output("no_pulse_overlap", overlap_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
